// File: rtl/irq_arbiter.sv
// Platform interrupt arbiter: per-source edge gateways, pending/in-service tracking,
// priority/threshold arbitration and a claim/complete handshake in front of the CSR file.
module irq_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3,
  parameter int ID_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_we,
  input  logic               cfg_re,
  input  logic [7:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  input  logic               claim_req,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_req,
  input  logic [ID_W-1:0]    complete_id,
  output logic               external_interrupt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t             state_r;
  state_t             next_state_s;

  logic [PRIO_W-1:0]  prio_r [NUM_SRC];
  logic [NUM_SRC-1:0] enable_r;
  logic [PRIO_W-1:0]  thresh_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] in_service_r;
  logic [NUM_SRC-1:0] src_prev_r;

  logic [31:0]        cfg_rdata_r;
  logic               claim_valid_r;
  logic [ID_W-1:0]    claim_id_r;
  logic               ext_int_r;

  logic [NUM_SRC-1:0] edge_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic [NUM_SRC-1:0] pick_s;
  logic [PRIO_W-1:0]  win_prio_s;
  logic [ID_W-1:0]    win_id_s;
  logic [NUM_SRC-1:0] win_oh_s;
  logic               claim_go_s;
  logic [NUM_SRC-1:0] claim_clr_s;
  logic [NUM_SRC-1:0] comp_clr_s;
  logic [NUM_SRC-1:0] pending_next_s;
  logic [NUM_SRC-1:0] in_service_next_s;
  logic [PRIO_W-1:0]  rd_prio_s;
  logic [31:0]        rd_data_s;
  logic               unused_wdata_s;

  assign unused_wdata_s = ^cfg_wdata[31:NUM_SRC];

  // Gateway edges, eligibility and the highest-priority winner (strict > keeps lowest index on ties)
  always_comb begin
    edge_s     = src_irq & ~src_prev_r;
    eligible_s = {NUM_SRC{1'b0}};
    pick_s     = {NUM_SRC{1'b0}};
    win_prio_s = {PRIO_W{1'b0}};
    win_id_s   = {ID_W{1'b0}};
    win_oh_s   = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      eligible_s[i] = pending_r[i] & enable_r[i] & ~in_service_r[i] & (prio_r[i] > thresh_r);
      pick_s[i]     = eligible_s[i] & (prio_r[i] > win_prio_s);
      win_prio_s    = pick_s[i] ? prio_r[i] : win_prio_s;
      win_id_s      = pick_s[i] ? ID_W'(i + 1) : win_id_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      win_oh_s[i] = (win_id_s == ID_W'(i + 1));
    end
  end

  // Claim/complete effects on pending and in-service; a claim overrides a same-cycle edge
  always_comb begin
    claim_go_s = (state_r == IDLE) & claim_req;
    comp_clr_s = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      comp_clr_s[i] = complete_req & (complete_id == ID_W'(i + 1)) & in_service_r[i];
    end
    claim_clr_s       = claim_go_s ? win_oh_s : {NUM_SRC{1'b0}};
    pending_next_s    = (pending_r | edge_s) & ~claim_clr_s;
    in_service_next_s = (in_service_r & ~comp_clr_s) | claim_clr_s;
  end

  // Claim FSM next state
  always_comb begin
    next_state_s = IDLE;
    case (state_r)
      IDLE: begin
        if (claim_req) begin
          next_state_s = RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Config read mux; priority slots outside NUM_SRC fall through to zero
  always_comb begin
    rd_prio_s = {PRIO_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      rd_prio_s = rd_prio_s | ((cfg_addr == 8'(i)) ? prio_r[i] : {PRIO_W{1'b0}});
    end
    rd_data_s = 32'd0;
    case (cfg_addr)
      8'h20:   rd_data_s[NUM_SRC-1:0] = enable_r;
      8'h21:   rd_data_s[PRIO_W-1:0]  = thresh_r;
      8'h22:   rd_data_s[NUM_SRC-1:0] = pending_r;
      8'h23:   rd_data_s[NUM_SRC-1:0] = in_service_r;
      default: rd_data_s[PRIO_W-1:0]  = rd_prio_s;
    endcase
  end

  // Configuration registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        prio_r[i] <= {PRIO_W{1'b0}};
      end
      enable_r <= {NUM_SRC{1'b0}};
      thresh_r <= {PRIO_W{1'b0}};
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_addr == 8'(i)) begin
          prio_r[i] <= cfg_wdata[PRIO_W-1:0];
        end
      end
      case (cfg_addr)
        8'h20:   enable_r <= cfg_wdata[NUM_SRC-1:0];
        8'h21:   thresh_r <= cfg_wdata[PRIO_W-1:0];
        default: ;
      endcase
    end
  end

  // Gateway history, pending and in-service state
  always_ff @(posedge clock) begin
    if (reset) begin
      src_prev_r   <= {NUM_SRC{1'b0}};
      pending_r    <= {NUM_SRC{1'b0}};
      in_service_r <= {NUM_SRC{1'b0}};
    end else begin
      src_prev_r   <= src_irq;
      pending_r    <= pending_next_s;
      in_service_r <= in_service_next_s;
    end
  end

  // Claim FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Registered outputs: read data, claim response and interrupt line
  always_ff @(posedge clock) begin
    if (reset) begin
      cfg_rdata_r   <= 32'd0;
      claim_valid_r <= 1'b0;
      claim_id_r    <= {ID_W{1'b0}};
      ext_int_r     <= 1'b0;
    end else begin
      if (cfg_re) begin
        cfg_rdata_r <= rd_data_s;
      end
      claim_valid_r <= claim_go_s;
      if (claim_go_s) begin
        claim_id_r <= win_id_s;
      end
      ext_int_r <= |eligible_s;
    end
  end

  assign cfg_rdata          = cfg_rdata_r;
  assign claim_valid        = claim_valid_r;
  assign claim_id           = claim_id_r;
  assign external_interrupt = ext_int_r;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: claim IDs are scoreboarded through a queue,
// register and interrupt-line expectations are checked inline.
module tb_irq_arbiter;

  localparam int NUM_SRC = 8;
  localparam int PRIO_W  = 3;
  localparam int ID_W    = 4;

  logic               clock;
  logic               reset;
  logic [NUM_SRC-1:0] src_irq;
  logic               cfg_we;
  logic               cfg_re;
  logic [7:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic [31:0]        cfg_rdata;
  logic               claim_req;
  logic               claim_valid;
  logic [ID_W-1:0]    claim_id;
  logic               complete_req;
  logic [ID_W-1:0]    complete_id;
  logic               external_interrupt;

  int checks_s;
  int errors_s;
  logic [ID_W-1:0] exp_q [$];

  irq_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
    .clock              (clock),
    .reset              (reset),
    .src_irq            (src_irq),
    .cfg_we             (cfg_we),
    .cfg_re             (cfg_re),
    .cfg_addr           (cfg_addr),
    .cfg_wdata          (cfg_wdata),
    .cfg_rdata          (cfg_rdata),
    .claim_req          (claim_req),
    .claim_valid        (claim_valid),
    .claim_id           (claim_id),
    .complete_req       (complete_req),
    .complete_id        (complete_id),
    .external_interrupt (external_interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s++;
    if (obs !== exp) begin
      errors_s++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    cfg_re = 1'b1; cfg_addr = a;
    @(negedge clock);
    cfg_re = 1'b0;
    check(tag, cfg_rdata, exp);
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] m);
    src_irq = m;
    @(negedge clock);
    src_irq = 8'h00;
  endtask

  task automatic do_claim(input logic [ID_W-1:0] exp);
    claim_req = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock);
    claim_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_complete(input logic [ID_W-1:0] id);
    complete_req = 1'b1; complete_id = id;
    @(negedge clock);
    complete_req = 1'b0;
  endtask

  // Scoreboard: every claim_valid pulse must match the oldest expected ID
  always @(negedge clock) begin
    if (claim_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("claim_unexpected", 32'd1, 32'd0);
      end else begin
        check("claim_id", 32'(claim_id), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks_s = 0; errors_s = 0;
    reset = 1'b1; src_irq = 8'h00; cfg_we = 1'b0; cfg_re = 1'b0; cfg_addr = 8'h00;
    cfg_wdata = 32'd0; claim_req = 1'b0; complete_req = 1'b0; complete_id = 4'd0;
    tick(3);
    check("rst_ext", 32'(external_interrupt), 32'd0);
    check("rst_valid", 32'(claim_valid), 32'd0);
    check("rst_id", 32'(claim_id), 32'd0);
    check("rst_rdata", cfg_rdata, 32'd0);

    // Reset then idle: edges on all lines latch pending but nothing interrupts
    reset = 1'b0; src_irq = 8'hFF;
    tick(3);
    check("idle_ext", 32'(external_interrupt), 32'd0);
    for (int i = 0; i < NUM_SRC; i++) cfg_read(8'(i), 32'd0, "prio_rst");
    cfg_read(8'h20, 32'd0, "enable_rst");
    cfg_read(8'h21, 32'd0, "thresh_rst");
    cfg_read(8'h23, 32'd0, "insvc_rst");
    cfg_read(8'h22, 32'h0000_00FF, "pending_all");
    cfg_write(8'h22, 32'd0);
    cfg_read(8'h22, 32'h0000_00FF, "pending_ro");
    cfg_write(8'h30, 32'hFFFF_FFFF);
    cfg_read(8'h30, 32'd0, "unmapped");
    cfg_write(8'h00, 32'hFFFF_FFFF);
    cfg_read(8'h00, 32'd7, "prio_upper");
    tick(2);
    check("rdata_hold", cfg_rdata, 32'd7);
    reset = 1'b1; src_irq = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Single source: interrupt two cycles after the edge, claim returns ID 3
    cfg_write(8'h02, 32'd5);
    cfg_write(8'h20, 32'h04);
    cfg_write(8'h21, 32'd0);
    src_irq = 8'h04;
    @(negedge clock);
    src_irq = 8'h00;
    check("single_ext_t1", 32'(external_interrupt), 32'd0);
    @(negedge clock);
    check("single_ext_t2", 32'(external_interrupt), 32'd1);
    do_claim(4'd3);
    cfg_read(8'h22, 32'd0, "single_pending");
    check("single_ext_off", 32'(external_interrupt), 32'd0);
    cfg_read(8'h23, 32'h04, "single_insvc");

    // In-service blocking and complete handling
    pulse(8'h04);
    tick(3);
    check("insvc_block_ext", 32'(external_interrupt), 32'd0);
    cfg_read(8'h22, 32'h04, "insvc_pending");
    do_complete(4'd9);
    tick(2);
    check("complete9_ext", 32'(external_interrupt), 32'd0);
    cfg_read(8'h23, 32'h04, "complete9_insvc");
    do_complete(4'd3);
    tick(1);
    check("complete3_ext", 32'(external_interrupt), 32'd1);
    do_claim(4'd3);
    do_complete(4'd3);

    // Priority order and tie break to lowest index
    cfg_write(8'h01, 32'd4);
    cfg_write(8'h05, 32'd6);
    cfg_write(8'h06, 32'd6);
    cfg_write(8'h20, 32'h62);
    pulse(8'h62);
    tick(2);
    do_claim(4'd6);
    do_claim(4'd7);
    do_claim(4'd2);
    do_claim(4'd0);
    cfg_read(8'h23, 32'h62, "tie_insvc");
    check("tie_ext", 32'(external_interrupt), 32'd0);
    do_complete(4'd6);
    do_complete(4'd7);
    do_complete(4'd2);

    // Threshold masking, including the all-masking maximum threshold
    cfg_write(8'h00, 32'd3);
    cfg_write(8'h21, 32'd3);
    cfg_write(8'h20, 32'h01);
    pulse(8'h01);
    tick(3);
    check("thresh_mask", 32'(external_interrupt), 32'd0);
    cfg_write(8'h21, 32'd2);
    check("thresh_t1", 32'(external_interrupt), 32'd0);
    tick(1);
    check("thresh_t2", 32'(external_interrupt), 32'd1);
    do_claim(4'd1);
    do_complete(4'd1);
    cfg_write(8'h00, 32'd7);
    cfg_write(8'h21, 32'd7);
    pulse(8'h01);
    tick(3);
    check("thresh_max", 32'(external_interrupt), 32'd0);
    do_claim(4'd0);
    cfg_write(8'h21, 32'd2);
    do_claim(4'd1);
    do_complete(4'd1);

    // Held level produces exactly one claimable event
    src_irq = 8'h01;
    tick(2);
    do_claim(4'd1);
    tick(16);
    do_claim(4'd0);
    src_irq = 8'h00;
    do_complete(4'd1);

    // Edge in the same cycle as the claim of that source is dropped
    pulse(8'h01);
    tick(2);
    claim_req = 1'b1; src_irq = 8'h01;
    exp_q.push_back(4'd1);
    @(negedge clock);
    claim_req = 1'b0;
    @(negedge clock);
    src_irq = 8'h00;
    cfg_read(8'h22, 32'd0, "claim_edge_pending");
    cfg_read(8'h23, 32'h01, "claim_edge_insvc");

    // Claim and complete together: claim sees pre-complete eligibility
    pulse(8'h01);
    tick(2);
    claim_req = 1'b1; complete_req = 1'b1; complete_id = 4'd1;
    exp_q.push_back(4'd0);
    @(negedge clock);
    claim_req = 1'b0; complete_req = 1'b0;
    @(negedge clock);
    cfg_read(8'h23, 32'd0, "claimcomp_insvc");
    cfg_read(8'h22, 32'h01, "claimcomp_pending");
    check("claimcomp_ext", 32'(external_interrupt), 32'd1);

    // Reset alongside a claim request aborts it
    claim_req = 1'b1; reset = 1'b1;
    @(negedge clock);
    claim_req = 1'b0; reset = 1'b0;
    check("rst_claim_valid", 32'(claim_valid), 32'd0);
    tick(2);
    check("rst_claim_ext", 32'(external_interrupt), 32'd0);
    cfg_read(8'h20, 32'd0, "rst_claim_enable");

    tick(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
    $finish;
  end

endmodule
